// File: rtl/knn_dist_scheduler.sv
// Query scheduler for a KNN distance datapath: round-robin grant of one query,
// in-order issue of K candidate indices, result counting and a done handshake.
module knn_dist_scheduler #(
  parameter int BIT_WIDTH = 16,
  parameter int K         = 8,
  parameter int N_REQ     = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [N_REQ-1:0]             req_valid,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [N_REQ*BIT_WIDTH-1:0]   req_qp_x,
  input  logic [N_REQ*BIT_WIDTH-1:0]   req_qp_y,
  input  logic [N_REQ*BIT_WIDTH-1:0]   req_qp_z,
  output logic [BIT_WIDTH-1:0]         dp_qp_x,
  output logic [BIT_WIDTH-1:0]         dp_qp_y,
  output logic [BIT_WIDTH-1:0]         dp_qp_z,
  output logic                         dp_issue_valid,
  output logic [$clog2(K)-1:0]         dp_issue_idx,
  output logic                         dp_issue_last,
  input  logic                         dp_stall,
  input  logic                         dp_result_valid,
  output logic                         done_valid,
  input  logic                         done_ready,
  output logic [$clog2(N_REQ)-1:0]     done_id,
  output logic                         busy,
  output logic                         err
);
  localparam int IW = $clog2(K);
  localparam int NW = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [NW-1:0] rr_ptr, id_q, gnt_idx, rr_nxt;
  logic [NW:0]   cand;
  logic          gnt_any, grant;
  logic [IW-1:0] issue_cnt;
  logic [IW:0]   result_cnt;
  logic          issue_fire, res_en, res_kth, res_early, res_stray;

  logic [N_REQ-1:0][BIT_WIDTH-1:0] qx, qy, qz;
  assign qx = req_qp_x;
  assign qy = req_qp_y;
  assign qz = req_qp_z;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int o = 0; o < N_REQ; o++) begin
      cand = {1'b0, rr_ptr} + (NW+1)'(o);
      if (cand >= (NW+1)'(N_REQ)) cand = cand - (NW+1)'(N_REQ);
      if (!gnt_any && req_valid[cand[NW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[NW-1:0];
      end
    end
  end

  assign rr_nxt     = (gnt_idx == NW'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
  assign grant      = (state == IDLE) && gnt_any;
  assign issue_fire = (state == ISSUE) && !dp_stall;
  assign res_en     = dp_result_valid && (state == ISSUE || state == DRAIN);
  assign res_kth    = res_en && (result_cnt == (IW+1)'(K-1));
  // A result with no outstanding issue means the datapath got ahead of us.
  assign res_early  = dp_result_valid && (state == ISSUE) &&
                      (result_cnt >= {1'b0, issue_cnt});
  assign res_stray  = dp_result_valid && (state == IDLE || state == DONE);

  always_comb begin
    state_nxt      = state;
    req_ready      = '0;
    dp_issue_valid = 1'b0;
    dp_issue_last  = 1'b0;
    done_valid     = 1'b0;
    case (state)
      IDLE: if (gnt_any) begin
        req_ready[gnt_idx] = 1'b1;
        state_nxt          = ISSUE;
      end
      ISSUE: begin
        dp_issue_valid = !dp_stall;
        dp_issue_last  = !dp_stall && (issue_cnt == IW'(K-1));
        if (res_kth)            state_nxt = DONE;
        else if (dp_issue_last) state_nxt = DRAIN;
      end
      DRAIN: if (res_kth) state_nxt = DONE;
      DONE: begin
        done_valid = 1'b1;
        if (done_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Strobe must read zero for the whole time reset is held.
    req_ready = req_ready & {N_REQ{reset_n}};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      id_q       <= '0;
      issue_cnt  <= '0;
      result_cnt <= '0;
      dp_qp_x    <= '0;
      dp_qp_y    <= '0;
      dp_qp_z    <= '0;
      err        <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        rr_ptr     <= rr_nxt;
        id_q       <= gnt_idx;
        dp_qp_x    <= qx[gnt_idx];
        dp_qp_y    <= qy[gnt_idx];
        dp_qp_z    <= qz[gnt_idx];
        issue_cnt  <= '0;
        result_cnt <= '0;
      end else begin
        if (issue_fire) issue_cnt  <= issue_cnt + 1'b1;
        if (res_en)     result_cnt <= result_cnt + 1'b1;
      end
      if (res_stray || res_early) err <= 1'b1;
    end
  end

  assign dp_issue_idx = issue_cnt;
  assign busy         = (state != IDLE);
  assign done_id      = (state == DONE) ? id_q : '0;

endmodule

// File: tb/tb_knn_dist_scheduler.sv
// Directed bench for knn_dist_scheduler: table of full queries plus hand-built
// error and reset sequences. Datapath model returns each result one cycle after issue.
module tb_knn_dist_scheduler;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid, req_ready;
  logic [31:0] req_qp_x, req_qp_y, req_qp_z;
  logic [15:0] dp_qp_x, dp_qp_y, dp_qp_z;
  logic        dp_issue_valid, dp_issue_last, dp_stall, dp_result_valid;
  logic [2:0]  dp_issue_idx;
  logic        done_valid, done_ready, busy, err;
  logic        done_id;
  logic        rres, inj;

  int total = 0;
  int bad   = 0;

  knn_dist_scheduler #(.BIT_WIDTH(16), .K(8), .N_REQ(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_qp_x(req_qp_x), .req_qp_y(req_qp_y), .req_qp_z(req_qp_z),
    .dp_qp_x(dp_qp_x), .dp_qp_y(dp_qp_y), .dp_qp_z(dp_qp_z),
    .dp_issue_valid(dp_issue_valid), .dp_issue_idx(dp_issue_idx),
    .dp_issue_last(dp_issue_last), .dp_stall(dp_stall),
    .dp_result_valid(dp_result_valid),
    .done_valid(done_valid), .done_ready(done_ready), .done_id(done_id),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n)
    if (!reset_n) rres <= 1'b0;
    else          rres <= dp_issue_valid;
  assign dp_result_valid = rres | inj;

  typedef struct {
    logic [1:0]  rv;
    logic [31:0] x, y, z;
    logic [1:0]  rdy;
    logic        id;
    logic [15:0] ex, ey, ez;
    int          stall_after, stall_len, hold;
  } vec_t;
  vec_t vt[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Entered shortly after a rising edge with the DUT in IDLE.
  task automatic do_query(input vec_t v, input string tag);
    int n, cyc, last_cyc, stalled;
    bit got;
    req_valid = v.rv; req_qp_x = v.x; req_qp_y = v.y; req_qp_z = v.z;
    #1;
    chk({tag, "_rdy"}, req_ready, v.rdy);
    chk({tag, "_idle_busy"}, busy, 0);
    @(posedge clk); #1;
    chk({tag, "_rdy_off"}, req_ready, 0);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_qx"}, dp_qp_x, v.ex);
    chk({tag, "_qy"}, dp_qp_y, v.ey);
    chk({tag, "_qz"}, dp_qp_z, v.ez);
    n = 0; cyc = 0; last_cyc = -100; stalled = 0; got = 0;
    while (!got && cyc < 100) begin
      dp_stall = (v.stall_after >= 0 && n == v.stall_after + 1 && stalled < v.stall_len);
      #1;
      if (dp_stall) begin
        chk({tag, "_stall_noissue"}, dp_issue_valid, 0);
        stalled++;
      end
      if (dp_issue_valid) begin
        chk({tag, "_idx"}, dp_issue_idx, n);
        chk({tag, "_last"}, dp_issue_last, (n == 7));
        if (n == 7) last_cyc = cyc;
        n++;
      end
      if (done_valid) got = 1;
      else begin @(posedge clk); #1; cyc++; end
    end
    dp_stall = 1'b0;
    chk({tag, "_done_seen"}, got, 1);
    chk({tag, "_issue_cnt"}, n, 8);
    chk({tag, "_done_lat"}, cyc - last_cyc, 2);
    if (v.stall_len > 0) chk({tag, "_stall_cycles"}, stalled, v.stall_len);
    for (int h = 0; h <= v.hold; h++) begin
      done_ready = (h == v.hold);
      #1;
      chk({tag, "_done_valid"}, done_valid, 1);
      chk({tag, "_done_id"}, done_id, v.id);
      chk({tag, "_rdy_blocked"}, req_ready, 0);
      chk({tag, "_qx_stable"}, dp_qp_x, v.ex);
      @(posedge clk); #1;
    end
    done_ready = 1'b0;
    #1;
    chk({tag, "_done_clr"}, done_valid, 0);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    bit found;
    vt[0] = '{2'b01, 32'h0000_0003, 32'h0000_0004, 32'h0000_0005, 2'b01, 1'b0, 16'h0003, 16'h0004, 16'h0005, -1, 0, 0};
    vt[1] = '{2'b11, 32'h0011_0010, 32'h0021_0020, 32'h0031_0030, 2'b10, 1'b1, 16'h0011, 16'h0021, 16'h0031, -1, 0, 0};
    vt[2] = '{2'b11, 32'h0111_0110, 32'h0121_0120, 32'h0131_0130, 2'b01, 1'b0, 16'h0110, 16'h0120, 16'h0130, 2, 3, 0};
    vt[3] = '{2'b11, 32'hbeef_0001, 32'hcafe_0002, 32'hface_0003, 2'b10, 1'b1, 16'hbeef, 16'hcafe, 16'hface, -1, 0, 4};
    vt[4] = '{2'b10, 32'h1234_5678, 32'h9abc_def0, 32'h0f0f_f0f0, 2'b10, 1'b1, 16'h1234, 16'h9abc, 16'h0f0f, -1, 0, 0};
    vt[5] = '{2'b01, 32'hffff_0aaa, 32'heeee_0bbb, 32'hdddd_0ccc, 2'b01, 1'b0, 16'h0aaa, 16'h0bbb, 16'h0ccc, -1, 0, 0};
    vt[6] = '{2'b01, 32'h0001_ffff, 32'h0002_8000, 32'h0003_7fff, 2'b01, 1'b0, 16'hffff, 16'h8000, 16'h7fff, -1, 0, 0};
    vt[7] = '{2'b10, 32'h4444_1111, 32'h5555_2222, 32'h6666_3333, 2'b10, 1'b1, 16'h4444, 16'h5555, 16'h6666, 1, 2, 1};

    reset_n = 1'b0; req_valid = 2'b00; req_qp_x = '0; req_qp_y = '0; req_qp_z = '0;
    dp_stall = 1'b0; done_ready = 1'b0; inj = 1'b0;
    #2 req_valid = 2'b11; req_qp_x = 32'h5555_aaaa;
    #1;
    chk("rst_rdy", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_qx", dp_qp_x, 0);
    chk("rst_issue", dp_issue_valid, 0);
    chk("rst_done", done_valid, 0);
    @(posedge clk); @(posedge clk); #2;
    req_valid = 2'b00;
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) do_query(vt[i], $sformatf("v%0d", i));

    // Stray result while idle sets a sticky error.
    req_valid = 2'b00; inj = 1'b1;
    #1 chk("stray_err_pre", err, 0);
    @(posedge clk); #1;
    inj = 1'b0;
    chk("stray_err", err, 1);
    chk("stray_no_grant", busy, 0);
    repeat (3) @(posedge clk);
    #1 chk("stray_err_sticky", err, 1);

    // Grant to 0 (rr_ptr -> 1), then reset during issue of idx 4.
    req_valid = 2'b01; req_qp_x = 32'h0000_0007; req_qp_y = 32'h0000_0008; req_qp_z = 32'h0000_0009;
    #1 chk("mid_rdy", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b11;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      #1;
      if (dp_issue_valid && dp_issue_idx == 3'd4) found = 1;
      else begin @(posedge clk); #1; end
    end
    chk("mid_reach_idx4", found, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_rdy", req_ready, 0);
    chk("mid_rst_issue", dp_issue_valid, 0);
    chk("mid_rst_last", dp_issue_last, 0);
    chk("mid_rst_idx", dp_issue_idx, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_qx", dp_qp_x, 0);
    chk("mid_rst_done", done_valid, 0);
    @(posedge clk); #1;
    chk("mid_rst_done_hold", done_valid, 0);
    req_valid = 2'b00;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_done", done_valid, 0);
    do_query('{2'b11, 32'h00a1_00a0, 32'h00b1_00b0, 32'h00c1_00c0, 2'b01, 1'b0,
               16'h00a0, 16'h00b0, 16'h00c0, -1, 0, 0}, "post_rst");

    // Result arriving before any candidate was issued.
    req_valid = 2'b01; dp_stall = 1'b1;
    @(posedge clk); #1;
    inj = 1'b1;
    #1;
    chk("early_stalled", dp_issue_valid, 0);
    chk("early_err_pre", err, 0);
    @(posedge clk); #1;
    inj = 1'b0;
    chk("early_err", err, 1);
    dp_stall = 1'b0; req_valid = 2'b00;
    reset_n = 1'b0;
    #1 chk("early_err_rst", err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end
endmodule
